if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction queue between fetch and decode.
- Fetch can keep issuing while decode is stalled, up to DEPTH instructions.
- Decode sees registered pc/inst plus a valid flag.
- Supports pipeline flush (branch mispredict/exception) and a 1-cycle bypass when the queue is empty.

Parameters:
- ADDR_W, 32, pc width.
- INST_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all queued and output instructions.
- if_valid  in  1  fetch presents an instruction this cycle.
- if_pc  in  ADDR_W  pc of fetched instruction.
- if_inst  in  INST_W  fetched instruction.
- if_ready  out  1  queue can accept; combinational, = (count != DEPTH).
- id_stall  in  1  decode stalled (stall[2] from ctrl); outputs hold.
- id_valid  out  1  id_pc/id_inst hold a real instruction.
- id_pc  out  ADDR_W  pc to decode.
- id_inst  out  INST_W  instruction to decode.

Behaviour:
- Priority each clock edge: rst > flush > normal.
- rst:
  - count, rd_ptr, wr_ptr <= 0.
  - id_pc, id_inst <= 0; id_valid <= 0.
  - Storage contents don't-care.
- flush:
  - Same effect as rst on pointers, count and outputs.
  - A push offered in the flush cycle is discarded.
  - if_ready in the flush cycle still reflects the pre-flush count.
- push = if_valid & if_ready & !flush. A push offered with if_ready=0 is dropped; upstream must hold if_pc/if_inst and retry.
- Output advance when !id_stall:
  - Queue non-empty: outputs <= head entry; id_valid <= 1; rd_ptr++.
  - Queue empty and push: bypass. Outputs <= if_pc/if_inst; id_valid <= 1; entry not stored; count unchanged.
  - Queue empty, no push: outputs <= 0; id_valid <= 0 (bubble = nop, pc 0).
- When id_stall=1:
  - Outputs and id_valid hold.
  - Any push is written at wr_ptr; wr_ptr++.
- When !id_stall and queue non-empty: a push writes the tail in the same cycle as the head pops.
- count update:
  - +1 on stored push only.
  - -1 on pop only.
  - Unchanged on simultaneous push+pop, and on bypass.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. Count is log2(DEPTH)+1 bits; range 0..DEPTH.
- Full (count=DEPTH): if_ready=0. A pop in the same cycle does not re-enable a push that cycle; ready rises the next cycle.
- Latency:
  - Instruction pushed into an empty, unstalled queue appears on outputs after 1 cycle.
  - Otherwise it appears after (entries ahead of it + 1) unstalled cycles.
- Ordering: strict FIFO; no reordering, no duplication.
- Outputs are fully registered; only if_ready is combinational, and only from count.

Optional Feature:
- Macro: IFQ_STATS_EN.
- Defined: adds ports `occupancy out clog2(DEPTH+1)` (= count) and `high_water out clog2(DEPTH+1)`.
  - high_water is the maximum count since the last rst; it is not cleared by flush.
  - Both are 0 after rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset/bypass: rst 1 cycle, then push pc=0x100, inst=0x24010001 with id_stall=0 -> next cycle id_valid=1, id_pc=0x100, id_inst=0x24010001; count stays 0; following idle cycle outputs 0, id_valid=0.
- Fill under stall (DEPTH=4): id_stall=1, push pc 0x0,0x4,0x8,0xC -> if_ready=0 after 4th; 5th push with pc 0x10 dropped; release stall -> outputs 0x0,0x4,0x8,0xC on 4 consecutive cycles, then bubble.
- Simultaneous push/pop: queue holds 2 entries, id_stall=0, push every cycle for 6 cycles -> count stays 2; output order matches push order exactly.
- Flush: queue holds 3 entries with valid output, flush=1 and push same cycle -> next cycle id_valid=0, id_pc=0, count=0, if_ready=1; pushed instruction never appears.
- Wrap-around: 3*DEPTH pushes/pops with random id_stall -> scoreboard matches; no loss; pointers wrap without error.
- IFQ_STATS_EN: fill to 3, drain, flush -> high_water=3, occupancy=0; after rst high_water=0.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry fetch/decode instruction queue with empty-queue bypass and flush.
// Defining IFQ_STATS_EN adds the occupancy and high_water outputs.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [ADDR_W-1:0]          if_pc,
    input  logic [INST_W-1:0]          if_inst,
    output logic                       if_ready,
    input  logic                       id_stall,
    output logic                       id_valid,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [INST_W-1:0]          id_inst
`ifdef IFQ_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [$clog2(DEPTH+1)-1:0] high_water
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              empty, push, pop, bypass, store;

    assign if_ready = count_q != CW'(DEPTH);
    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;

    // A push into an empty, unstalled queue goes straight to the outputs and is never stored.
    always_comb begin
        empty      = count_q == '0;
        push       = if_valid & if_ready & ~flush;
        pop        = ~id_stall & ~empty;
        bypass     = ~id_stall & empty & push;
        store      = push & ~bypass;
        rd_d       = flush ? '0 : rd_q + PW'(pop);
        wr_d       = flush ? '0 : wr_q + PW'(store);
        count_d    = flush ? '0 : count_q + CW'(store) - CW'(pop);
        id_valid_d = flush ? 1'b0 : id_stall ? id_valid_q : (pop | bypass);
        id_pc_d    = flush ? '0 : id_stall ? id_pc_q : pop ? pc_mem[rd_q] : bypass ? if_pc : '0;
        id_inst_d  = flush ? '0 : id_stall ? id_inst_q : pop ? inst_mem[rd_q] : bypass ? if_inst : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            pc_mem[wr_q]   <= if_pc;
            inst_mem[wr_q] <= if_inst;
        end
    end

`ifdef IFQ_STATS_EN
    logic [CW-1:0] hw_q, hw_d;

    // Flush empties the queue but deliberately keeps the high-water mark.
    always_comb hw_d = count_d > hw_q ? count_d : hw_q;

    always_ff @(posedge clk) begin
        if (rst) hw_q <= '0;
        else     hw_q <= hw_d;
    end

    assign occupancy  = count_q;
    assign high_water = hw_q;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: random and directed stimulus checked every cycle against a queue-based model.
module tb_if_id_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, id_stall, if_ready, id_valid;
    logic [31:0] if_pc, if_inst, id_pc, id_inst;
`ifdef IFQ_STATS_EN
    logic [CW-1:0] occupancy, high_water;
`endif

    always #5 clk = ~clk;

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid),
        .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
`ifdef IFQ_STATS_EN
        , .occupancy(occupancy), .high_water(high_water)
`endif
    );

    typedef struct packed { logic [31:0] epc; logic [31:0] einst; } ent_t;
    ent_t        mq[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0, m_inst = '0;
    int          m_hw = 0;
    int          n_chk = 0, n_fail = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance the model across the clock edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic st, input logic fl, input logic rs);
        bit   push;
        ent_t e;
        if_valid = v; if_pc = pc; if_inst = inst; id_stall = st; flush = fl; rst = rs;
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
            m_valid = 1'b0; m_pc = '0; m_inst = '0;
            if (rs) m_hw = 0;
        end else begin
            push = v && mq.size() != DEPTH;
            if (!st) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    m_valid = 1'b1; m_pc = e.epc; m_inst = e.einst;
                end else if (push) begin
                    m_valid = 1'b1; m_pc = pc; m_inst = inst;
                    push = 1'b0;
                end else begin
                    m_valid = 1'b0; m_pc = '0; m_inst = '0;
                end
            end
            if (push) mq.push_back('{pc, inst});
            if (mq.size() > m_hw) m_hw = mq.size();
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("id_valid", 32'(id_valid), 32'(m_valid));
            chk("id_pc", id_pc, m_pc);
            chk("id_inst", id_inst, m_inst);
            chk("if_ready", 32'(if_ready), 32'(mq.size() != DEPTH));
`ifdef IFQ_STATS_EN
            chk("occupancy", 32'(occupancy), 32'(mq.size()));
            chk("high_water", 32'(high_water), 32'(m_hw));
`endif
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_ready", 32'(if_ready), 1);

        step(1, 32'h100, 32'h24010001, 0, 0, 0);
        chk("bp_valid", 32'(id_valid), 1);
        chk("bp_pc", id_pc, 32'h100);
        chk("bp_inst", id_inst, 32'h24010001);
`ifdef IFQ_STATS_EN
        chk("bp_count", 32'(occupancy), 0);
`endif
        step(0, 0, 0, 0, 0, 0);
        chk("bubble_valid", 32'(id_valid), 0);
        chk("bubble_pc", id_pc, 0);

        for (int i = 0; i < 4; i++) step(1, 32'(4*i), 32'hA000_0000 + 32'(i), 1, 0, 0);
        chk("full_ready", 32'(if_ready), 0);
        step(1, 32'h10, 32'hDEAD_0010, 1, 0, 0);
        step(1, 32'h10, 32'hDEAD_0010, 0, 0, 0);
        chk("drain_pc0", id_pc, 32'h0);
        chk("ready_rise", 32'(if_ready), 1);
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("drain_pc", id_pc, 32'(4*i));
        end
        step(0, 0, 0, 0, 0, 0);
        chk("drain_end_valid", 32'(id_valid), 0);

        step(1, 32'h200, 32'hB000_0000, 1, 0, 0);
        step(1, 32'h204, 32'hB000_0001, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 32'h208 + 32'(4*i), 32'hB000_0002 + 32'(i), 0, 0, 0);
        chk("simul_pc", id_pc, 32'h214);
        chk("simul_inst", id_inst, 32'hB000_0005);
`ifdef IFQ_STATS_EN
        chk("simul_count", 32'(occupancy), 2);
`endif
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        step(1, 32'h300, 32'hC000_0000, 0, 0, 0);
        for (int i = 1; i < 4; i++) step(1, 32'h300 + 32'(4*i), 32'hC000_0000 + 32'(i), 1, 0, 0);
        chk("pre_flush_pc", id_pc, 32'h300);
        step(1, 32'h400, 32'hC000_0400, 0, 1, 0);
        chk("flush_valid", 32'(id_valid), 0);
        chk("flush_pc", id_pc, 0);
        chk("flush_ready", 32'(if_ready), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("post_flush_valid", 32'(id_valid), 0);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);

`ifdef IFQ_STATS_EN
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(4*i), 32'(i), 1, 0, 0);
        chk("stats_occ3", 32'(occupancy), 3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("stats_hw_flush", 32'(high_water), 3);
        chk("stats_occ_flush", 32'(occupancy), 0);
        step(0, 0, 0, 0, 0, 1);
        chk("stats_hw_rst", 32'(high_water), 0);
`endif
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
